fb_pixel_source: RTL and testbench

Double-buffered low-resolution framebuffer that sits directly upstream of the VGA timing generator.
- Read side: each cycle it takes the generator's next_x/next_y, fetches the pixel from the display bank, expands it through a fixed 8-entry palette and drives the generator's input_red/green/blue.
- Write side: game logic draws into the hidden bank through a valid/ready port.
- Bank swaps are requested by handshake and committed only in vertical blanking, so frames never tear.

---
 rtl/fb_pkg.sv | 48 ++++
 rtl/fb_pixel_source_if.sv | 30 +++
 rtl/fb_bank_ram.sv | 26 ++
 rtl/fb_pixel_source.sv | 148 ++++++++++++++
 tb/tb_fb_pixel_source.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the double-buffered pixel source: geometry, colour index,
// fixed palette, control-FSM states and the row-major pixel offset helper.
package fb_pkg;

  localparam int FB_W      = 160;
  localparam int FB_H      = 120;
  localparam int FB_PIXELS = FB_W * FB_H;
  localparam int OFF_W     = 15;
  localparam int ADDR_W    = 16;

  typedef logic [2:0] color_idx_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    DRAW    = 2'd0,
    WAIT_VS = 2'd1,
    SWAP    = 2'd2,
    CLEAR   = 2'd3
  } fb_state_t;

  localparam rgb_t PALETTE [8] = '{
    '{8'h00, 8'h00, 8'h00},
    '{8'hFF, 8'h00, 8'h00},
    '{8'h00, 8'hFF, 8'h00},
    '{8'h00, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'h00},
    '{8'h00, 8'hFF, 8'hFF},
    '{8'hFF, 8'h00, 8'hFF},
    '{8'hFF, 8'hFF, 8'hFF}
  };

  // y*160 + x built from shifts so no multiplier is inferred.
  function automatic logic [OFF_W-1:0] pix_offset(input logic [6:0] y, input logic [7:0] x);
    logic [OFF_W-1:0] y7;
    logic [OFF_W-1:0] y5;
    logic [OFF_W-1:0] xx;
    y7 = {1'b0, y, 7'b0};
    y5 = {3'b0, y, 5'b0};
    xx = {7'b0, x};
    return y7 + y5 + xx;
  endfunction

endpackage

// File: rtl/fb_pixel_source_if.sv
// Bundle between the pixel source and its neighbours: VGA scan coordinates and RGB,
// the draw port (valid/ready) and the swap request/ack handshake.
interface fb_pixel_source_if;
  import fb_pkg::*;

  logic [9:0] next_x;
  logic [9:0] next_y;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  color_idx_t wr_color;
  logic       swap_req;
  logic       swap_ack;
  logic       frame_start;
  logic [7:0] output_red;
  logic [7:0] output_green;
  logic [7:0] output_blue;

  modport master (
    output next_x, next_y, wr_valid, wr_x, wr_y, wr_color, swap_req,
    input  wr_ready, swap_ack, frame_start, output_red, output_green, output_blue
  );

  modport slave (
    input  next_x, next_y, wr_valid, wr_x, wr_y, wr_color, swap_req,
    output wr_ready, swap_ack, frame_start, output_red, output_green, output_blue
  );

endinterface

// File: rtl/fb_bank_ram.sv
// Simple dual-port RAM holding both framebuffer banks; one write port, registered read,
// 1-cycle read latency, no backpressure. Contents are deliberately not reset.
module fb_bank_ram #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fb_pixel_source.sv
// Double-buffered 160x120 framebuffer feeding the VGA generator: RGB 1 cycle after next_x/y.
// Draw port is ready only in DRAW; swaps commit at the frame boundary, then the new draw bank is cleared.
module fb_pixel_source
  import fb_pkg::*;
#(
  parameter int SCALE_SHIFT   = 2,
  parameter bit CLEAR_ON_SWAP = 1'b1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  fb_pixel_source_if.slave bus
);

  fb_state_t        r_state;
  logic             r_disp_bank;
  logic [OFF_W-1:0] r_clr_cnt;
  logic             r_rd_valid;
  logic [9:0]       r_prev_y;
  logic             r_frame_start;
  logic             r_swap_ack;
  logic             r_wr_ready;

  logic [9:0]        w_sx;
  logic [9:0]        w_sy;
  logic [7:0]        w_fx;
  logic [6:0]        w_fy;
  logic [OFF_W-1:0]  w_rd_off;
  logic [OFF_W-1:0]  w_wr_off;
  logic              w_wr_in_range;
  logic              w_wr_fire;
  logic              w_ram_we;
  logic [ADDR_W-1:0] w_ram_waddr;
  logic [ADDR_W-1:0] w_ram_raddr;
  color_idx_t        w_ram_wdata;
  color_idx_t        w_rd_idx;
  rgb_t              w_rgb;

  // Screen -> framebuffer coordinate, clamped so x=640 and y=478/479 hit the last pixel.
  assign w_sx = bus.next_x >> SCALE_SHIFT;
  assign w_sy = bus.next_y >> SCALE_SHIFT;
  assign w_fx = (w_sx >= 10'(FB_W)) ? 8'(FB_W - 1) : w_sx[7:0];
  assign w_fy = (w_sy >= 10'(FB_H)) ? 7'(FB_H - 1) : w_sy[6:0];

  assign w_rd_off    = pix_offset(w_fy, w_fx);
  assign w_ram_raddr = {r_disp_bank, w_rd_off};

  assign w_wr_in_range = (bus.wr_x < 8'(FB_W)) && (bus.wr_y < 7'(FB_H));
  assign w_wr_fire     = bus.wr_valid && r_wr_ready;
  assign w_wr_off      = pix_offset(bus.wr_y, bus.wr_x);

  // Writers only ever touch the hidden bank, so reads and writes never collide.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = {~r_disp_bank, w_wr_off};
    w_ram_wdata = bus.wr_color;
    if (r_state == CLEAR) begin
      w_ram_we    = 1'b1;
      w_ram_waddr = {~r_disp_bank, r_clr_cnt};
      w_ram_wdata = '0;
    end else if (w_wr_fire && w_wr_in_range) begin
      w_ram_we = 1'b1;
    end
  end

  fb_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (3)
  ) u_ram (
    .i_clk   (CLOCK_50),
    .i_we    (w_ram_we),
    .i_waddr (w_ram_waddr),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_rd_idx)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_prev_y      <= '0;
      r_frame_start <= 1'b0;
      r_rd_valid    <= 1'b0;
    end else begin
      r_prev_y      <= bus.next_y;
      r_frame_start <= (r_prev_y != 10'd0) && (bus.next_y == 10'd0);
      r_rd_valid    <= 1'b1;
    end
  end

  // Bank toggles on entry to SWAP together with the ack, so the ack marks a committed swap.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= DRAW;
      r_disp_bank <= 1'b0;
      r_clr_cnt   <= '0;
      r_swap_ack  <= 1'b0;
      r_wr_ready  <= 1'b1;
    end else begin
      r_swap_ack <= 1'b0;
      case (r_state)
        DRAW: begin
          if (bus.swap_req) begin
            r_state    <= WAIT_VS;
            r_wr_ready <= 1'b0;
          end
        end
        WAIT_VS: begin
          if (r_frame_start) begin
            r_state     <= SWAP;
            r_disp_bank <= ~r_disp_bank;
            r_swap_ack  <= 1'b1;
          end
        end
        SWAP: begin
          if (CLEAR_ON_SWAP) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
          end else begin
            r_state    <= DRAW;
            r_wr_ready <= 1'b1;
          end
        end
        CLEAR: begin
          if (r_clr_cnt == OFF_W'(FB_PIXELS - 1)) begin
            r_clr_cnt  <= '0;
            r_state    <= DRAW;
            r_wr_ready <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= DRAW;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  assign w_rgb = r_rd_valid ? PALETTE[w_rd_idx] : '0;

  assign bus.output_red   = w_rgb.r;
  assign bus.output_green = w_rgb.g;
  assign bus.output_blue  = w_rgb.b;
  assign bus.wr_ready     = r_wr_ready;
  assign bus.swap_ack     = r_swap_ack;
  assign bus.frame_start  = r_frame_start;

endmodule

// File: tb/tb_fb_pixel_source.sv
// Bench for fb_pixel_source: fixed read table, model-checked random draws/reads,
// swap handshake timing, clear length and reset during clear.
module tb_fb_pixel_source;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  int   disp_m;
  int   mem [2][19200];
  int   wq [$];

  typedef struct {
    int          nx;
    int          ny;
    logic [23:0] rgb;
  } rd_vec_t;

  rd_vec_t vt [11];

  fb_pixel_source_if u_if ();

  fb_pixel_source dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: run still going after 95000 cycles, required to end earlier");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Palette rule: bit set per channel according to the colour list.
  function automatic logic [23:0] rgb_of(input int idx);
    logic [7:0] r, g, b;
    r = (idx == 1 || idx == 4 || idx == 6 || idx == 7) ? 8'hFF : 8'h00;
    g = (idx == 2 || idx == 4 || idx == 5 || idx == 7) ? 8'hFF : 8'h00;
    b = (idx == 3 || idx == 5 || idx == 6 || idx == 7) ? 8'hFF : 8'h00;
    return {r, g, b};
  endfunction

  function automatic logic [23:0] dut_rgb();
    return {u_if.output_red, u_if.output_green, u_if.output_blue};
  endfunction

  task automatic model_write(input int x, input int y, input int c);
    if (x < 160 && y < 120) begin
      mem[1 - disp_m][y * 160 + x] = c;
      wq.push_back(y * 160 + x);
    end
  endtask

  task automatic wr_px(input int x, input int y, input int c);
    u_if.wr_valid = 1'b1;
    u_if.wr_x     = 8'(x);
    u_if.wr_y     = 7'(y);
    u_if.wr_color = 3'(c);
    chk("wr_ready_draw", {31'b0, u_if.wr_ready}, 1);
    step();
    model_write(x, y, c);
    u_if.wr_valid = 1'b0;
  endtask

  task automatic rd_model(input int nx, input int ny, input string nm);
    int fx, fy, v;
    fx = nx / 4;
    fy = ny / 4;
    if (fx > 159) fx = 159;
    if (fy > 119) fy = 119;
    v = mem[disp_m][fy * 160 + fx];
    u_if.next_x = 10'(nx);
    u_if.next_y = 10'(ny);
    step();
    if (v >= 0) chk(nm, {8'b0, dut_rgb()}, {8'b0, rgb_of(v)});
  endtask

  task automatic rd_off(input int o, input string nm);
    rd_model((o % 160) * 4 + int'($urandom_range(0, 3)), (o / 160) * 4 + int'($urandom_range(0, 2)), nm);
  endtask

  // Full swap handshake; abort_at >= 0 asserts reset once the clear counter reaches that value.
  task automatic do_swap(input bit wr_too, input int wx, input int wy, input int wc, input int abort_at);
    int  n;
    bit  done;
    int  b;
    u_if.next_y = 10'd100;
    step();
    u_if.swap_req = 1'b1;
    u_if.wr_valid = wr_too;
    u_if.wr_x     = 8'(wx);
    u_if.wr_y     = 7'(wy);
    u_if.wr_color = 3'(wc);
    chk("swap_ready_before", {31'b0, u_if.wr_ready}, 1);
    step();
    if (wr_too) model_write(wx, wy, wc);
    u_if.wr_valid = 1'b0;
    chk("wait_vs_ready", {31'b0, u_if.wr_ready}, 0);
    u_if.next_y = 10'd478;
    step();
    chk("frame_start_early", {31'b0, u_if.frame_start}, 0);
    chk("ack_before_vs", {31'b0, u_if.swap_ack}, 0);
    u_if.next_y = 10'd0;
    step();
    chk("frame_start_pulse", {31'b0, u_if.frame_start}, 1);
    chk("ack_with_fs", {31'b0, u_if.swap_ack}, 0);
    u_if.next_y = 10'd4;
    step();
    chk("swap_ack_pulse", {31'b0, u_if.swap_ack}, 1);
    chk("frame_start_drop", {31'b0, u_if.frame_start}, 0);
    chk("swap_ready", {31'b0, u_if.wr_ready}, 0);
    u_if.swap_req = 1'b0;
    disp_m = 1 - disp_m;
    b = 1 - disp_m;
    if (abort_at >= 0) begin
      repeat (abort_at + 1) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_rgb", {8'b0, dut_rgb()}, 0);
      chk("abort_ready", {31'b0, u_if.wr_ready}, 1);
      chk("abort_ack", {31'b0, u_if.swap_ack}, 0);
      for (int o = 0; o < abort_at + 6; o++) mem[b][o] = (o < abort_at - 5) ? 0 : -1;
      disp_m = 0;
      for (int i = 0; i < 3; i++) begin
        step();
        chk("abort_no_ack", {31'b0, u_if.swap_ack}, 0);
      end
    end else begin
      n = 0;
      done = 1'b0;
      while (!done && n < 19300) begin
        step();
        n++;
        if (n == 1) chk("swap_ack_drop", {31'b0, u_if.swap_ack}, 0);
        if (u_if.wr_ready) done = 1'b1;
      end
      chk("clear_length", n, 19201);
      for (int o = 0; o < 19200; o++) mem[b][o] = 0;
    end
  endtask

  initial begin
    int v, x, y, c;
    n_checks = 0;
    n_err    = 0;
    disp_m   = 0;
    for (int k = 0; k < 2; k++)
      for (int o = 0; o < 19200; o++) mem[k][o] = -1;

    vt[0]  = '{40,  20,  24'hFF0000};
    vt[1]  = '{640, 478, 24'hFFFFFF};
    vt[2]  = '{0,   0,   24'h0000FF};
    vt[3]  = '{636, 12,  24'hFFFF00};
    vt[4]  = '{320, 240, 24'h00FFFF};
    vt[5]  = '{4,   0,   24'hFF00FF};
    vt[6]  = '{11,  3,   24'h00FF00};
    vt[7]  = '{2,   18,  24'h0000FF};
    vt[8]  = '{380, 4,   24'h00FFFF};
    vt[9]  = '{43,  23,  24'hFF0000};
    vt[10] = '{639, 477, 24'hFFFFFF};

    rst = 1'b1;
    u_if.next_x = '0;  u_if.next_y = '0;
    u_if.wr_valid = 1'b0; u_if.wr_x = '0; u_if.wr_y = '0; u_if.wr_color = '0;
    u_if.swap_req = 1'b0;
    repeat (3) step();
    chk("reset_rgb", {8'b0, dut_rgb()}, 0);
    chk("reset_ready", {31'b0, u_if.wr_ready}, 1);
    chk("reset_ack", {31'b0, u_if.swap_ack}, 0);
    chk("reset_fs", {31'b0, u_if.frame_start}, 0);
    rst = 1'b0;
    step();
    chk("post_reset_ready", {31'b0, u_if.wr_ready}, 1);
    chk("post_reset_ack", {31'b0, u_if.swap_ack}, 0);

    // Bank 1 content, including out-of-range writes that would alias if not dropped.
    wr_px(10, 5, 1);   wr_px(159, 119, 7); wr_px(0, 0, 3);   wr_px(159, 3, 4);
    wr_px(80, 60, 5);  wr_px(1, 0, 6);     wr_px(2, 0, 2);   wr_px(0, 4, 3);
    wr_px(95, 1, 5);   wr_px(160, 3, 2);
    chk("drop_ready", {31'b0, u_if.wr_ready}, 1);
    wr_px(255, 0, 1);  wr_px(5, 120, 6);
    do_swap(1'b0, 0, 0, 0, -1);
    for (int i = 0; i < 11; i++) begin
      u_if.next_x = 10'(vt[i].nx);
      u_if.next_y = 10'(vt[i].ny);
      step();
      chk($sformatf("table_%0d", i), {8'b0, dut_rgb()}, {8'b0, vt[i].rgb});
    end

    wq.delete();
    for (int i = 0; i < 150; i++) begin
      v = int'($urandom_range(0, 1));
      x = int'($urandom_range(0, 170));
      y = int'($urandom_range(0, 125));
      c = int'($urandom_range(0, 7));
      u_if.wr_valid = v[0];
      u_if.wr_x = 8'(x); u_if.wr_y = 7'(y); u_if.wr_color = 3'(c);
      chk("rand_wr_ready", {31'b0, u_if.wr_ready}, 1);
      step();
      if (v != 0) model_write(x, y, c);
    end
    u_if.wr_valid = 1'b0;
    do_swap(1'b1, 20, 10, 4, -1);
    u_if.next_x = 10'd81; u_if.next_y = 10'd41;
    step();
    chk("swap_cycle_write", {8'b0, dut_rgb()}, 32'h00FFFF00);
    for (int i = 0; i < 60; i++) begin
      if (wq.size() > 0) rd_off(wq[$urandom_range(0, wq.size() - 1)], "rand_read");
    end

    do_swap(1'b0, 0, 0, 0, 5000);
    rd_off(0, "abort_cleared_0");
    rd_off(100, "abort_cleared_100");
    rd_off(4000, "abort_cleared_4000");
    foreach (wq[i]) if (wq[i] > 5010 && i < 40) rd_off(wq[i], "abort_kept");

    do_swap(1'b0, 0, 0, 0, -1);
    for (int i = 0; i < 30; i++)
      rd_model(int'($urandom_range(0, 640)), int'($urandom_range(0, 478)), "cleared_bank");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
